rv_sequencer: RTL and testbench
===============================

Name: rv_sequencer

Overview:
- Multicycle control sequencer for the RV32I datapath.
- Fetches instructions over a valid-handshake instruction port and decodes them into the 23-bit control word plus pc and imm.
- Holds each control word stable long enough for the registered datapath stages to settle, then commits exactly once.
- Computes the next PC (sequential, branch, jal, jalr) and halts on ECALL/EBREAK, illegal opcodes or misaligned targets.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset.
HOLD_CYCLES, 5, datapath settle cycles per instruction before commit (min 3).

Ports:
clk  in  1  clock; all state updates on posedge.
rst  in  1  asynchronous active-low reset; resets on negedge rst.
imem_req  out  1  fetch request, held high in FETCH until accepted.
imem_addr  out  32  fetch address, equals pc.
imem_rdata  in  32  instruction word, valid when imem_valid=1.
imem_valid  in  1  one-cycle acceptance/data strobe.
rs1_val  in  32  datapath rs1 read data (r_for_pc).
rs2_val  in  32  datapath rs2 read data.
cword  out  23  {rs2[22:18], rs1[17:13], rd[12:8], fun7[7], fun3[6:4], instType[3:0]}.
pc  out  32  PC of the current instruction.
imm  out  32  sign-extended immediate of the current instruction.
halted  out  1  sticky, set by ECALL/EBREAK.
trap  out  1  sticky, set by illegal opcode or misaligned target.

Behaviour:
- Reset (async, rst=0): state=IDLE, pc=RESET_PC, imm=0, cword=BUBBLE, imem_req=0, halted=0, trap=0. Reset mid-instruction aborts it; no commit occurs.
- BUBBLE = instType 6, all other fields 0; the datapath writes neither the regfile nor memory.
- instType codes: load 0, imm 1, store 2, reg 3, lui 4, auipc 5, branch 6, jalr 7, jal 8.
- FSM transitions:
  - IDLE -> FETCH after 1 cycle.
  - FETCH: imem_req=1, imem_addr=pc. On imem_valid, latch the instruction -> DECODE.
  - DECODE, 1 cycle:
    - Classify opcode: 0000011 load, 0010011 imm, 0100011 store, 0110011 reg, 0110111 lui, 0010111 auipc, 1100011 branch, 1100111 jalr, 1101111 jal.
    - 1110011 -> HALT. Any other opcode -> TRAP.
    - Build cword: fun3=instr[14:12]; fun7=instr[30] for reg, and for imm when fun3=101, else 0; rd/rs1/rs2 from instr fields.
    - Build imm as I/S/B/U/J, sign-extended; U = {instr[31:12],12'b0}.
    - -> EXEC.
  - EXEC, HOLD_CYCLES cycles, counter 0..HOLD_CYCLES-1:
    - cword presented with rd forced to 0, and instType 2 presented as 1.
    - On the last count -> COMMIT.
  - COMMIT, 1 cycle:
    - Full cword presented (real rd, real store type). This is the only regfile/memory write window.
    - Next PC:
      - branch taken: pc+immB. Taken per fun3: 000 eq, 001 ne, 100 lt signed, 101 ge signed, 110 ltu, 111 geu; fun3 010/011 -> TRAP.
      - jal: pc+immJ.
      - jalr: (rs1_val+immI) & ~1.
      - else: pc+4.
    - Next PC with [1:0]!=0 -> TRAP, pc unchanged. Otherwise pc<=next, cword<=BUBBLE -> FETCH.
  - HALT: halted=1, cword=BUBBLE, imem_req=0; absorbing until reset.
  - TRAP: trap=1, otherwise identical to HALT.
- Arithmetic: 32-bit wraparound; pc 32'hFFFF_FFFC+4 = 0, with no trap.
- Branch operands are sampled in COMMIT only; rs1_val/rs2_val in other states are ignored.
- imem_valid outside FETCH is ignored. imem_rdata is captured only on the cycle imem_valid=1 in FETCH.
- Cycles per instruction: 3 + HOLD_CYCLES + imem wait cycles.

Test Plan:
- Reset and first fetch: reset released, imem_valid returned 2 cycles after imem_req -> imem_addr=0; addi x1,x0,5 (32'h00500093): cword.rd=0 during EXEC, rd=1 only in COMMIT, instType=1, imm=5; next fetch at 4 after exactly 3+5+2 cycles.
- Branch taken and not taken: beq x1,x2,-8 at pc 0x20 with rs1_val=rs2_val=7 -> next fetch 0x18; rs2_val=8 -> next fetch 0x24. bltu with rs1=1, rs2=32'hFFFF_FFFF -> taken.
- jalr alignment: jalr x1,4(x5) with rs1_val=0x101 -> next pc 0x104 (bit0 cleared). rs1_val=0x102 -> trap=1, pc held, no further imem_req.
- Store masking: sw x2,8(x1) -> instType 1 with rd=0 throughout EXEC, instType 2 for exactly 1 cycle (COMMIT), imm=8.
- Halt/illegal: ECALL 32'h00000073 -> halted=1 and cword stays BUBBLE for 100 cycles. Opcode 7'b1111111 -> trap=1.
- Async reset mid-EXEC: rst low at EXEC count 2 -> outputs immediately at reset values, pc=RESET_PC, no COMMIT cword emitted.

Source files
------------

// File: rtl/rv_sequencer_if.sv
// Instruction fetch port of the RV32I multicycle sequencer.
// req/addr are held while fetching; valid is a one-cycle data strobe.
interface rv_sequencer_if;
  logic        req;
  logic [31:0] addr;
  logic [31:0] rdata;
  logic        valid;

  modport master (
    output req,
    output addr,
    input  rdata,
    input  valid
  );

  modport slave (
    input  req,
    input  addr,
    output rdata,
    output valid
  );
endinterface

// File: rtl/rv_sequencer.sv
// Multicycle RV32I control sequencer: fetch, decode, hold, commit.
// Computes next PC and stops on ECALL/EBREAK, bad opcodes, bad targets.
module rv_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned HOLD_CYCLES = 5
) (
  input  logic           clk,
  input  logic           rst,
  rv_sequencer_if.master imem,
  input  logic [31:0]    rs1_val,
  input  logic [31:0]    rs2_val,
  output logic [22:0]    cword,
  output logic [31:0]    pc,
  output logic [31:0]    imm,
  output logic           halted,
  output logic           trap
);

  localparam int unsigned CW =
    (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);

  localparam logic [3:0] T_LOAD   = 4'd0;
  localparam logic [3:0] T_IMM    = 4'd1;
  localparam logic [3:0] T_STORE  = 4'd2;
  localparam logic [3:0] T_REG    = 4'd3;
  localparam logic [3:0] T_LUI    = 4'd4;
  localparam logic [3:0] T_AUIPC  = 4'd5;
  localparam logic [3:0] T_BRANCH = 4'd6;
  localparam logic [3:0] T_JALR   = 4'd7;
  localparam logic [3:0] T_JAL    = 4'd8;

  localparam logic [22:0] BUBBLE = {19'd0, T_BRANCH};

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_COMMIT,
    S_HALT,
    S_TRAP
  } state_e;

  state_e        state;
  state_e        state_nx;
  logic [CW-1:0] cnt;
  logic [31:0]   instr;
  logic [31:0]   pc_q;
  logic [31:0]   imm_q;
  logic [22:0]   cw_q;

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;

  logic [3:0]  dty;
  logic [31:0] dimm;
  logic        df7;
  logic        dlegal;
  logic        dsys;

  logic [3:0]  cty;
  logic [2:0]  cf3;
  logic        taken;
  logic        bad_f3;
  logic [31:0] pc_nx;
  logic        commit_bad;

  assign opc   = instr[6:0];
  assign f3    = instr[14:12];
  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7],
                  instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'd0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12],
                  instr[20], instr[30:21], 1'b0};

  always_comb begin
    dty    = T_BRANCH;
    dimm   = '0;
    df7    = 1'b0;
    dlegal = 1'b1;
    dsys   = 1'b0;
    unique case (1'b1)
      opc == OP_LOAD: begin
        dty  = T_LOAD;
        dimm = imm_i;
      end
      opc == OP_IMM: begin
        dty  = T_IMM;
        dimm = imm_i;
        df7  = (f3 == 3'b101) & instr[30];
      end
      opc == OP_STORE: begin
        dty  = T_STORE;
        dimm = imm_s;
      end
      opc == OP_REG: begin
        dty = T_REG;
        df7 = instr[30];
      end
      opc == OP_LUI: begin
        dty  = T_LUI;
        dimm = imm_u;
      end
      opc == OP_AUIPC: begin
        dty  = T_AUIPC;
        dimm = imm_u;
      end
      opc == OP_BRANCH: begin
        dty  = T_BRANCH;
        dimm = imm_b;
      end
      opc == OP_JALR: begin
        dty  = T_JALR;
        dimm = imm_i;
      end
      opc == OP_JAL: begin
        dty  = T_JAL;
        dimm = imm_j;
      end
      opc == OP_SYSTEM: dsys = 1'b1;
      default: dlegal = 1'b0;
    endcase
  end

  assign cty = cw_q[3:0];
  assign cf3 = cw_q[6:4];

  // Register operands are only trusted here, in the commit cycle.
  always_comb begin
    taken  = 1'b0;
    bad_f3 = 1'b0;
    unique case (cf3)
      3'b000: taken = rs1_val == rs2_val;
      3'b001: taken = rs1_val != rs2_val;
      3'b100: taken = $signed(rs1_val) < $signed(rs2_val);
      3'b101: taken = $signed(rs1_val) >= $signed(rs2_val);
      3'b110: taken = rs1_val < rs2_val;
      3'b111: taken = rs1_val >= rs2_val;
      default: bad_f3 = 1'b1;
    endcase
  end

  always_comb begin
    pc_nx = pc_q + 32'd4;
    unique case (1'b1)
      cty == T_BRANCH: begin
        if (taken) pc_nx = pc_q + imm_q;
      end
      cty == T_JAL:  pc_nx = pc_q + imm_q;
      cty == T_JALR: pc_nx = (rs1_val + imm_q) & ~32'd1;
      default: ;
    endcase
  end

  assign commit_bad = ((cty == T_BRANCH) && bad_f3) ||
                      (pc_nx[1:0] != 2'b00);

  always_comb begin
    state_nx = state;
    imem.req = 1'b0;
    cword    = BUBBLE;
    halted   = 1'b0;
    trap     = 1'b0;
    unique case (state)
      S_IDLE: state_nx = S_FETCH;
      S_FETCH: begin
        imem.req = 1'b1;
        if (imem.valid) state_nx = S_DECODE;
      end
      S_DECODE: begin
        if (dsys)        state_nx = S_HALT;
        else if (dlegal) state_nx = S_EXEC;
        else             state_nx = S_TRAP;
      end
      S_EXEC: begin
        // No write side effects until commit: rd=0, store shown as imm.
        cword = {cw_q[22:13], 5'd0, cw_q[7:4],
                 (cty == T_STORE) ? T_IMM : cty};
        if (cnt == LAST) state_nx = S_COMMIT;
      end
      S_COMMIT: begin
        cword    = cw_q;
        state_nx = commit_bad ? S_TRAP : S_FETCH;
      end
      S_HALT: halted = 1'b1;
      S_TRAP: trap   = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      instr <= '0;
      pc_q  <= RESET_PC;
      imm_q <= '0;
      cw_q  <= BUBBLE;
    end else begin
      state <= state_nx;
      unique case (state)
        S_FETCH: begin
          if (imem.valid) instr <= imem.rdata;
        end
        S_DECODE: begin
          cw_q  <= {instr[24:20], instr[19:15], instr[11:7],
                    df7, f3, dty};
          imm_q <= dimm;
          cnt   <= '0;
        end
        S_EXEC: begin
          cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
        S_COMMIT: begin
          if (!commit_bad) begin
            pc_q <= pc_nx;
            cw_q <= BUBBLE;
          end
        end
        default: ;
      endcase
    end
  end

  assign imem.addr = pc_q;
  assign pc        = pc_q;
  assign imm       = imm_q;

endmodule

// File: tb/tb_rv_sequencer.sv
// Bench for rv_sequencer: directed and random instructions against
// a per-instruction reference built from the instruction's meaning.
module tb_rv_sequencer;

  localparam int HOLD = 5;
  localparam logic [22:0] BUB = 23'd6;

  typedef struct packed {
    logic [3:0]  ty;
    logic        f7;
    logic [31:0] imm;
    logic [31:0] npc;
    logic [1:0]  fate;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [22:0] cword;
  logic [31:0] pc;
  logic [31:0] imm;
  logic        halted;
  logic        trap;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_pc;

  rv_sequencer_if bus ();

  rv_sequencer #(
    .RESET_PC    (32'h0),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .imem    (bus),
    .rs1_val (rs1_val),
    .rs2_val (rs2_val),
    .cword   (cword),
    .pc      (pc),
    .imm     (imm),
    .halted  (halted),
    .trap    (trap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // kind: 0 load 1 imm 2 store 3 reg 4 lui 5 auipc 6 branch
  //       7 jalr 8 jal 9 ecall 10 illegal
  // fate: 0 normal, 1 halt, 2 decode trap, 3 commit trap
  task automatic mk(input int kind,
                    input logic [4:0] rd, a, b,
                    input logic [2:0] f3,
                    input logic f7,
                    input logic [31:0] iv, r1, r2,
                    output logic [31:0] ins,
                    output exp_t e);
    logic [31:0] si, sb, su, sj, rnd;
    logic tk;
    si = {{20{iv[11]}}, iv[11:0]};
    sb = {{19{iv[12]}}, iv[12:1], 1'b0};
    su = {iv[31:12], 12'd0};
    sj = {{11{iv[20]}}, iv[20:1], 1'b0};
    e.ty   = kind[3:0];
    e.f7   = 1'b0;
    e.imm  = si;
    e.npc  = m_pc + 32'd4;
    e.fate = 2'd0;
    tk     = 1'b0;
    case (kind)
      0: ins = {iv[11:0], a, f3, rd, 7'b0000011};
      1: begin
        ins  = {iv[11:0], a, f3, rd, 7'b0010011};
        e.f7 = (f3 == 3'd5) ? iv[10] : 1'b0;
      end
      2: ins = {iv[11:5], b, a, f3, iv[4:0], 7'b0100011};
      3: begin
        ins  = {1'b0, f7, 5'd0, b, a, f3, rd, 7'b0110011};
        e.f7 = f7;
      end
      4: begin
        ins   = {iv[31:12], rd, 7'b0110111};
        e.imm = su;
      end
      5: begin
        ins   = {iv[31:12], rd, 7'b0010111};
        e.imm = su;
      end
      6: begin
        ins = {iv[12], iv[10:5], b, a, f3, iv[4:1], iv[11],
               7'b1100011};
        e.imm = sb;
        case (f3)
          3'd0: tk = r1 == r2;
          3'd1: tk = r1 != r2;
          3'd4: tk = $signed(r1) < $signed(r2);
          3'd5: tk = $signed(r1) >= $signed(r2);
          3'd6: tk = r1 < r2;
          3'd7: tk = r1 >= r2;
          default: e.fate = 2'd3;
        endcase
        if (tk) e.npc = m_pc + sb;
      end
      7: begin
        ins   = {iv[11:0], a, 3'b000, rd, 7'b1100111};
        e.npc = (r1 + si) & ~32'd1;
      end
      8: begin
        ins = {iv[20], iv[10:1], iv[11], iv[19:12], rd,
               7'b1101111};
        e.imm = sj;
        e.npc = m_pc + sj;
      end
      9: begin
        ins    = 32'h0000_0073;
        e.fate = 2'd1;
      end
      default: begin
        rnd    = $urandom;
        ins    = {rnd[24:0], 7'h7F};
        e.fate = 2'd2;
      end
    endcase
    if (e.fate == 2'd0 && e.npc[1:0] != 2'b00) e.fate = 2'd3;
  endtask

  // Entered at a negedge in FETCH; leaves at the next FETCH negedge.
  task automatic run_instr(input logic [31:0] ins,
                           input exp_t e,
                           input logic [31:0] r1, r2,
                           input int wt);
    logic [22:0] full, mask;
    logic [3:0]  mty;
    mty  = (e.ty == 4'd2) ? 4'd1 : e.ty;
    full = {ins[24:20], ins[19:15], ins[11:7], e.f7,
            ins[14:12], e.ty};
    mask = {ins[24:20], ins[19:15], 5'd0, e.f7,
            ins[14:12], mty};
    chk("fetch_req", {31'd0, bus.req}, 32'd1);
    chk("fetch_addr", bus.addr, m_pc);
    for (int i = 0; i < wt; i++) begin
      bus.valid = 1'b0;
      rs1_val   = $urandom;
      @(negedge clk);
      chk("wait_req", {31'd0, bus.req}, 32'd1);
    end
    bus.valid = 1'b1;
    bus.rdata = ins;
    @(negedge clk);
    bus.valid = 1'b0;
    bus.rdata = $urandom;
    chk("decode_cw", {9'd0, cword}, {9'd0, BUB});
    if (e.fate == 2'd1 || e.fate == 2'd2) begin
      @(negedge clk);
      chk("stop_flags", {30'd0, halted, trap},
          (e.fate == 2'd1) ? 32'd2 : 32'd1);
      chk("stop_req", {31'd0, bus.req}, 32'd0);
      chk("stop_cw", {9'd0, cword}, {9'd0, BUB});
      return;
    end
    for (int k = 1; k <= HOLD; k++) begin
      rs1_val   = $urandom;
      rs2_val   = $urandom;
      bus.valid = 1'($urandom_range(0, 1));
      bus.rdata = $urandom;
      @(negedge clk);
      chk("exec_cw", {9'd0, cword}, {9'd0, mask});
      if (e.ty != 4'd3) chk("exec_imm", imm, e.imm);
      chk("exec_pc", pc, m_pc);
      chk("exec_req", {31'd0, bus.req}, 32'd0);
    end
    rs1_val   = $urandom;
    rs2_val   = $urandom;
    bus.valid = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk("commit_cw", {9'd0, cword}, {9'd0, full});
    rs1_val   = r1;
    rs2_val   = r2;
    bus.valid = 1'($urandom_range(0, 1));
    @(negedge clk);
    bus.valid = 1'b0;
    if (e.fate == 2'd3) begin
      chk("ctrap_flag", {30'd0, trap, bus.req}, 32'd2);
      chk("ctrap_pc", pc, m_pc);
    end else begin
      chk("next_req", {31'd0, bus.req}, 32'd1);
      chk("next_addr", bus.addr, e.npc);
      chk("next_cw", {9'd0, cword}, {9'd0, BUB});
      m_pc = e.npc;
    end
  endtask

  task automatic step(input int kind,
                      input logic [4:0] rd, a, b,
                      input logic [2:0] f3,
                      input logic [31:0] iv, r1, r2,
                      input int wt);
    logic [31:0] ins;
    exp_t e;
    mk(kind, rd, a, b, f3, 1'b0, iv, r1, r2, ins, e);
    run_instr(ins, e, r1, r2, wt);
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    bus.valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out", {6'd0, bus.req, halted, trap, cword},
        {6'd0, 3'b000, BUB});
    chk("rst_pc", pc, 32'h0);
    chk("rst_imm", imm, 32'h0);
    rst  = 1'b1;
    m_pc = 32'h0;
    @(negedge clk);
    chk("first_req", {31'd0, bus.req}, 32'd1);
    chk("first_addr", bus.addr, 32'h0);
  endtask

  initial begin
    logic [31:0] ins;
    exp_t        e;
    bus.valid = 1'b0;
    bus.rdata = '0;
    rs1_val   = '0;
    rs2_val   = '0;
    m_pc      = '0;

    do_reset();
    step(1, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5, 0, 0, 2);
    step(8, 5'd0, 5'd0, 5'd0, 3'd0, 32'd28, 0, 0, 1);
    step(6, 5'd0, 5'd1, 5'd2, 3'd0, 32'hFFFF_FFF8, 7, 7, 0);
    step(8, 5'd0, 5'd0, 5'd0, 3'd0, 32'd8, 0, 0, 0);
    step(6, 5'd0, 5'd1, 5'd2, 3'd0, 32'hFFFF_FFF8, 7, 8, 1);
    step(6, 5'd0, 5'd1, 5'd2, 3'd6, 32'd8, 1, 32'hFFFF_FFFF, 0);
    step(2, 5'd0, 5'd1, 5'd2, 3'd2, 32'd8, 0, 0, 0);
    step(7, 5'd1, 5'd5, 5'd0, 3'd0, 32'd4, 32'h101, 0, 1);
    step(7, 5'd0, 5'd5, 5'd0, 3'd0, 32'd4, 32'hFFFF_FFF8, 0, 0);
    step(1, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5, 0, 0, 0);

    for (int n = 0; n < 60; n++) begin
      int          kind;
      logic [31:0] iv, r1, r2, si, tgt;
      logic [4:0]  rd, a, b;
      logic [2:0]  f3;
      logic        f7;
      kind = int'($urandom_range(0, 8));
      rd   = 5'($urandom);
      a    = 5'($urandom);
      b    = 5'($urandom);
      f3   = 3'($urandom);
      f7   = 1'($urandom);
      iv   = $urandom;
      r1   = $urandom;
      r2   = $urandom;
      if (kind == 6) begin
        case ($urandom_range(0, 5))
          0: f3 = 3'd0;
          1: f3 = 3'd1;
          2: f3 = 3'd4;
          3: f3 = 3'd5;
          4: f3 = 3'd6;
          default: f3 = 3'd7;
        endcase
        iv = ($urandom_range(0, 2047) - 32'd1024) << 2;
        if ($urandom_range(0, 1) == 1) r2 = r1;
      end else if (kind == 8) begin
        iv = ($urandom_range(0, 65535) - 32'd32768) << 2;
      end else if (kind == 7) begin
        f3  = 3'd0;
        si  = {{20{iv[11]}}, iv[11:0]};
        tgt = $urandom & ~32'd3;
        r1  = tgt - si + ($urandom & 32'd1);
      end
      mk(kind, rd, a, b, f3, f7, iv, r1, r2, ins, e);
      run_instr(ins, e, r1, r2, int'($urandom_range(0, 3)));
    end

    step(7, 5'd1, 5'd5, 5'd0, 3'd0, 32'd4, 32'h102, 0, 0);
    for (int i = 0; i < 20; i++) begin
      bus.valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("trap_hold", {29'd0, trap, halted, bus.req}, 32'd4);
      chk("trap_pc", pc, m_pc);
    end

    do_reset();
    step(9, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0, 0, 0, 1);
    for (int i = 0; i < 100; i++) begin
      bus.valid = 1'($urandom_range(0, 1));
      bus.rdata = $urandom;
      @(negedge clk);
      chk("halt_hold", {6'd0, halted, trap, bus.req, cword},
          {6'd0, 3'b100, BUB});
    end

    do_reset();
    step(10, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0, 0, 0, 0);

    do_reset();
    step(6, 5'd0, 5'd1, 5'd2, 3'd2, 32'd8, 1, 1, 0);

    do_reset();
    step(8, 5'd0, 5'd0, 5'd0, 3'd0, 32'd32, 0, 0, 0);
    mk(1, 5'd3, 5'd0, 5'd0, 3'd0, 1'b0, 32'd9, 0, 0, ins, e);
    bus.valid = 1'b1;
    bus.rdata = ins;
    @(negedge clk);
    bus.valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_cw", {9'd0, cword},
        {9'd0, ins[24:20], ins[19:15], 5'd0, 1'b0, 3'd0, 4'd1});
    chk("pre_rst_pc", pc, 32'h20);
    rst = 1'b0;
    #1;
    chk("async_cw", {9'd0, cword}, {9'd0, BUB});
    chk("async_pc", pc, 32'h0);
    chk("async_imm", imm, 32'h0);
    chk("async_req", {31'd0, bus.req}, 32'd0);
    do_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
